hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker.sv | 137 +++++++++++++
 tb/tb_hazard_tracker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: pipeline bookkeeping that feeds a hazard unit.
// Tracks the register addresses and control bits of the Execute, Memory
// and Writeback stages, compares source operands against downstream
// destinations, and counts stall/flush events.
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   RA1D, RA2D, WA3D       Decode-stage source/destination addresses
//   RegWriteD, MemtoRegD,
//   PCSrcD, BranchD        Decode-stage control bits
//   CondExE                Execute-stage condition-pass flag
//   StallD, FlushD, FlushE stall/flush requests (FlushE bubbles E)
//   Match*                 operand/destination address comparisons
//   MemtoRegE, RegWriteM,
//   RegWriteW, PCSrcW      pipelined control bits
//   BranchTakenE,
//   PCWrPendingF           derived control
//   StallCount, FlushCount saturating event counters
module hazard_tracker #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              BranchD,
  input  logic              CondExE,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  output logic              Match1E_M,
  output logic              Match1E_W,
  output logic              Match2E_M,
  output logic              Match2E_W,
  output logic              Match12D_E,
  output logic              MemtoRegE,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic              BranchTakenE,
  output logic              PCWrPendingF,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ADDR_W-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
  logic              RegWriteE, PCSrcE, BranchE;
  logic              MemtoRegM, PCSrcM, MemtoRegW;
  logic              unusedSink;

  // MemtoRegW is carried for the datapath's benefit; nothing here reads it.
  assign unusedSink = MemtoRegW;

  // Decode -> Execute; FlushE replaces the whole slot with a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      BranchE   <= 1'b0;
    end else if (FlushE) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      BranchE   <= 1'b0;
    end else begin
      RA1E      <= RA1D;
      RA2E      <= RA2D;
      WA3E      <= WA3D;
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      PCSrcE    <= PCSrcD;
      BranchE   <= BranchD;
    end
  end

  // Execute -> Memory -> Writeback; a failed condition squashes the write and PC redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      PCSrcM    <= 1'b0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      WA3M      <= WA3E;
      RegWriteM <= RegWriteE & CondExE;
      MemtoRegM <= MemtoRegE;
      PCSrcM    <= PCSrcE & CondExE;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;
    end
  end

  // Saturating event counters; a cycle with both flushes counts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != CNT_MAX))
        StallCount <= StallCount + CNT_W'(1);
      if ((FlushD || FlushE) && (FlushCount != CNT_MAX))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

  // Address comparisons are intentionally not qualified by RegWrite.
  always_comb begin
    Match1E_M    = (RA1E == WA3M);
    Match1E_W    = (RA1E == WA3W);
    Match2E_M    = (RA2E == WA3M);
    Match2E_W    = (RA2E == WA3W);
    Match12D_E   = (RA1D == WA3E) | (RA2D == WA3E);
    BranchTakenE = BranchE & CondExE;
    // PCSrcW is excluded: by Writeback the PC write has already landed.
    PCWrPendingF = PCSrcD | PCSrcE | (PCSrcE & CondExE) | PCSrcM;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] RA1D, RA2D, WA3D;
  logic          RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE;
  logic          StallD, FlushD, FlushE;
  logic          Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E;
  logic          MemtoRegE, RegWriteM, RegWriteW, PCSrcW, BranchTakenE, PCWrPendingF;
  logic [CW-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  hazard_tracker #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
    .CondExE(CondExE), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Match1E_M(Match1E_M), .Match1E_W(Match1E_W), .Match2E_M(Match2E_M),
    .Match2E_W(Match2E_W), .Match12D_E(Match12D_E),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // One recorded Decode-stage instruction per clock edge, plus the
  // Execute-side inputs seen at that same edge.
  typedef struct packed {
    logic [AW-1:0] ra1, ra2, wa3;
    logic          rw, mtr, pcs, br;
    logic          flushE, cond;
  } ent_t;

  ent_t hist[$];
  int   stallExp = 0;
  int   flushExp = 0;
  localparam int CMAX = (1 << CW) - 1;

  // Reference history: what was presented at each edge since reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      stallExp = 0;
      flushExp = 0;
    end else begin
      hist.push_back({RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchD, FlushE, CondExE});
      if (hist.size() > 4) void'(hist.pop_front());
      if (StallD && stallExp < CMAX) stallExp++;
      if ((FlushD || FlushE) && flushExp < CMAX) flushExp++;
    end
  end

  // Entry recorded k edges ago (1 = most recent); zero before reset release.
  function automatic ent_t back(int k);
    int n = hist.size();
    if (k > n) return '0;
    return hist[n-k];
  endfunction

  // The instruction that entered Execute from a recorded edge.
  function automatic ent_t intoE(ent_t x);
    ent_t r = x;
    if (x.flushE) r = '0;
    r.cond = 1'b0;
    r.flushE = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the history-based reference.
  always @(negedge clk) begin
    ent_t e, m, w;
    logic mCond, wCond, expRwM, expPcsM, expRwW, expPcsW;
    e = intoE(back(1));
    m = intoE(back(2));
    w = intoE(back(3));
    mCond = back(1).cond;
    wCond = back(2).cond;
    expRwM  = m.rw & mCond;
    expPcsM = m.pcs & mCond;
    expRwW  = w.rw & wCond;
    expPcsW = w.pcs & wCond;
    chk("Match1E_M", 32'(Match1E_M), 32'(e.ra1 == m.wa3));
    chk("Match1E_W", 32'(Match1E_W), 32'(e.ra1 == w.wa3));
    chk("Match2E_M", 32'(Match2E_M), 32'(e.ra2 == m.wa3));
    chk("Match2E_W", 32'(Match2E_W), 32'(e.ra2 == w.wa3));
    chk("Match12D_E", 32'(Match12D_E), 32'((RA1D == e.wa3) || (RA2D == e.wa3)));
    chk("MemtoRegE", 32'(MemtoRegE), 32'(e.mtr));
    chk("RegWriteM", 32'(RegWriteM), 32'(expRwM));
    chk("RegWriteW", 32'(RegWriteW), 32'(expRwW));
    chk("PCSrcW", 32'(PCSrcW), 32'(expPcsW));
    chk("BranchTakenE", 32'(BranchTakenE), 32'(e.br & CondExE));
    chk("PCWrPendingF", 32'(PCWrPendingF), 32'(PCSrcD | e.pcs | expPcsM));
    chk("StallCount", 32'(StallCount), 32'(stallExp));
    chk("FlushCount", 32'(FlushCount), 32'(flushExp));
  end

  task automatic driveD(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                        input logic [AW-1:0] wa3, input logic rw, input logic mtr,
                        input logic pcs, input logic br);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs; BranchD = br;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    driveD(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    repeat (n) nextCycle();
  endtask

  // Producer writes r5 under condition c, consumer reads r5 in the next two slots.
  task automatic raw5(input logic c);
    CondExE = c;
    driveD(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    driveD(4'd5, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_raw_c1_Match12D_E", 32'(Match12D_E), 32'd1);
    nextCycle();
    @(negedge clk);
    chk("lit_raw_c2_Match1E_M", 32'(Match1E_M), 32'd1);
    chk("lit_raw_c2_RegWriteM", 32'(RegWriteM), 32'(c));
    nextCycle();
    @(negedge clk);
    chk("lit_raw_c3_Match1E_W", 32'(Match1E_W), 32'd1);
    chk("lit_raw_c3_RegWriteW", 32'(RegWriteW), 32'(c));
    nextCycle();
  endtask

  initial begin
    reset = 1'b1;
    CondExE = 1'b0;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_Match1E_M", 32'(Match1E_M), 32'd1);
    chk("lit_rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("lit_rst_StallCount", 32'(StallCount), 32'd0);
    reset = 1'b0;
    idle(2);

    // Forwarding chain with the condition passing, then failing.
    raw5(1'b1);
    idle(3);
    raw5(1'b0);
    idle(3);

    // Load followed by a dependent instruction that is flushed out of Execute.
    CondExE = 1'b1;
    driveD(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    driveD(4'd0, 4'd3, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    FlushE = 1'b1;
    @(negedge clk);
    chk("lit_flush_MemtoRegE", 32'(MemtoRegE), 32'd1);
    chk("lit_flush_Match12D_E", 32'(Match12D_E), 32'd1);
    nextCycle();
    idle(0);
    @(negedge clk);
    chk("lit_flush_bubble_MemtoRegE", 32'(MemtoRegE), 32'd0);
    nextCycle();
    @(negedge clk);
    chk("lit_flush_load_RegWriteW", 32'(RegWriteW), 32'd1);
    nextCycle();
    @(negedge clk);
    chk("lit_flush_bubble_RegWriteW", 32'(RegWriteW), 32'd0);
    idle(3);

    // One-cycle PC redirect walking down the pipe.
    CondExE = 1'b1;
    driveD(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_pc_c0_pending", 32'(PCWrPendingF), 32'd1);
    nextCycle();
    idle(0);
    @(negedge clk);
    chk("lit_pc_c1_pending", 32'(PCWrPendingF), 32'd1);
    nextCycle();
    @(negedge clk);
    chk("lit_pc_c2_pending", 32'(PCWrPendingF), 32'd1);
    nextCycle();
    @(negedge clk);
    chk("lit_pc_c3_pending", 32'(PCWrPendingF), 32'd0);
    chk("lit_pc_c3_PCSrcW", 32'(PCSrcW), 32'd1);
    idle(3);

    // Branch resolution follows the live condition flag.
    driveD(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    idle(0);
    CondExE = 1'b1;
    #1;
    chk("lit_branch_taken", 32'(BranchTakenE), 32'd1);
    CondExE = 1'b0;
    #1;
    chk("lit_branch_not_taken", 32'(BranchTakenE), 32'd0);
    idle(3);

    // Stall counter saturation, then flush counting (one earlier FlushE already counted).
    StallD = 1'b1;
    repeat (70000) nextCycle();
    StallD = 1'b0;
    @(negedge clk);
    chk("lit_stall_saturated", 32'(StallCount), 32'h0000_FFFF);
    nextCycle();
    FlushD = 1'b1; FlushE = 1'b1;
    nextCycle();
    FlushE = 1'b0;
    @(negedge clk);
    chk("lit_flush_both_once", 32'(FlushCount), 32'd2);
    nextCycle();
    FlushD = 1'b0;
    @(negedge clk);
    chk("lit_flushD_only", 32'(FlushCount), 32'd3);
    idle(3);

    // Reset mid-stream with a write in Memory.
    CondExE = 1'b1;
    driveD(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    idle(1);
    @(negedge clk);
    chk("lit_pre_rst_RegWriteM", 32'(RegWriteM), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_rst_async_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("lit_rst_async_Match1E_M", 32'(Match1E_M), 32'd1);
    chk("lit_rst_async_StallCount", 32'(StallCount), 32'd0);
    chk("lit_rst_async_FlushCount", 32'(FlushCount), 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_RegWriteW", 32'(RegWriteW), 32'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
